// File: rtl/pll_seq_pkg.sv
// Shared constants for the PLL reset sequencer: state encodings, default timing, loss filter length.
// Optional lock-loss filter is enabled by defining PLL_SEQ_LOCK_FILTER_EN.
package pll_seq_pkg;

  localparam logic [2:0] PLL_RST   = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] STABLE    = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] FAIL      = 3'd4;

  localparam int unsigned DEF_RST_HOLD_CYCLES     = 12;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 12000;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1200;
  localparam int unsigned DEF_MAX_RETRIES         = 7;
  localparam int unsigned DEF_CNT_W               = 16;

  localparam int unsigned LOSS_FILTER_LEN = 4;
  localparam int unsigned FILT_W          = $clog2(LOSS_FILTER_LEN);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with synchronous active-low reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// iCE40 PLL reset sequencer in the 12 MHz reference domain: RESETB pulsing, lock timeout/retry, core reset gating.
// Define PLL_SEQ_LOCK_FILTER_EN to ignore lock-low glitches shorter than LOSS_FILTER_LEN cycles in STABLE/RUN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W               = DEF_CNT_W
) (
  input  logic       clk_12m,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       clear_stats,
  output logic       pll_resetb,
  output logic       core_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_count,
  output logic [7:0] lock_loss_count
);

  logic             lock_s;
  logic             lock_lost;
  logic             run_loss;
  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [2:0]       retry_nx;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk_12m),
    .rst_n (rst_n),
    .d     (locked),
    .q     (lock_s)
  );

`ifdef PLL_SEQ_LOCK_FILTER_EN
  logic [FILT_W-1:0] filt_cnt;

  // Loss is declared on the LOSS_FILTER_LEN-th consecutive low sample.
  assign lock_lost = !lock_s && (filt_cnt == FILT_W'(LOSS_FILTER_LEN - 1));

  always_ff @(posedge clk_12m) begin
    if (!rst_n) begin
      filt_cnt <= '0;
    end else if (lock_s || (state_nx != state)) begin
      filt_cnt <= '0;
    end else if (state == STABLE || state == RUN) begin
      filt_cnt <= filt_cnt + FILT_W'(1);
    end
  end
`else
  assign lock_lost = !lock_s;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    retry_nx = retry_count;
    run_loss = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == CNT_W'(RST_HOLD_CYCLES - 1)) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        // Lock seen on the timeout cycle takes priority over the retry.
        if (lock_s) begin
          state_nx = STABLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          cnt_nx = '0;
          if (retry_count == 3'(MAX_RETRIES)) begin
            state_nx = FAIL;
          end else begin
            state_nx = PLL_RST;
            retry_nx = retry_count + 3'd1;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      STABLE: begin
        if (lock_lost) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (lock_lost) begin
          state_nx = PLL_RST;
          cnt_nx   = '0;
          retry_nx = 3'd0;
          run_loss = 1'b1;
        end
      end
      FAIL: begin
        state_nx = FAIL;
      end
      default: begin
        state_nx = PLL_RST;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state register.
  always_ff @(posedge clk_12m) begin
    if (!rst_n) begin
      state           <= PLL_RST;
      cnt             <= '0;
      retry_count     <= '0;
      lock_loss_count <= '0;
      pll_resetb      <= 1'b0;
      core_rst_n      <= 1'b0;
      ready           <= 1'b0;
      fail            <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      retry_count <= retry_nx;
      pll_resetb  <= !((state_nx == PLL_RST) || (state_nx == FAIL));
      core_rst_n  <= (state_nx == RUN);
      ready       <= (state_nx == RUN);
      fail        <= (state_nx == FAIL);
      if (clear_stats) begin
        lock_loss_count <= '0;
      end else if (run_loss) begin
        lock_loss_count <= sat_inc8(lock_loss_count);
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed scoreboard bench for pll_reset_sequencer with short timing parameters.
module tb_pll_reset_sequencer;

  localparam int unsigned RST_HOLD = 4;
  localparam int unsigned TIMEOUT  = 20;
  localparam int unsigned STABLE_N = 10;
  localparam int unsigned MAXR     = 2;
`ifdef PLL_SEQ_LOCK_FILTER_EN
  localparam int unsigned LAT = 6;
`else
  localparam int unsigned LAT = 3;
`endif

  logic       clk_12m = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic       clear_stats = 1'b0;
  logic       pll_resetb;
  logic       core_rst_n;
  logic       ready;
  logic       fail;
  logic [2:0] retry_count;
  logic [7:0] lock_loss_count;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES     (RST_HOLD),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT),
    .LOCK_STABLE_CYCLES  (STABLE_N),
    .MAX_RETRIES         (MAXR),
    .CNT_W               (16)
  ) dut (
    .clk_12m         (clk_12m),
    .rst_n           (rst_n),
    .locked          (locked),
    .clear_stats     (clear_stats),
    .pll_resetb      (pll_resetb),
    .core_rst_n      (core_rst_n),
    .ready           (ready),
    .fail            (fail),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clk_12m = ~clk_12m;

  typedef struct {
    string       tag;
    logic [14:0] exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_llc = 8'd0;
  logic [14:0] obs;

  assign obs = {pll_resetb, core_rst_n, ready, fail, retry_count, lock_loss_count};

  // {pll_resetb, core_rst_n, ready, fail, retry_count, lock_loss_count}
  function automatic logic [14:0] vec(input logic rb, input logic cr, input logic fl,
                                      input logic [2:0] rc, input logic [7:0] llc);
    return {rb, cr, cr, fl, rc, llc};
  endfunction

  task automatic tick();
    @(posedge clk_12m);
    #1;
  endtask

  task automatic step(input string tag, input logic [14:0] e);
    exp_t it;
    sb.push_back('{tag: tag, exp: e});
    tick();
    it = sb.pop_front();
    checks++;
    assert (obs === it.exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
    end
  endtask

  task automatic steps(input int unsigned n, input string tag, input logic [14:0] e);
    for (int unsigned i = 0; i < n; i++) step(tag, e);
  endtask

  task automatic do_reset(input logic lk);
    rst_n = 1'b0;
    locked = lk;
    clear_stats = 1'b0;
    exp_llc = 8'd0;
    steps(2, "reset", vec(0, 0, 0, 3'd0, 8'd0));
    rst_n = 1'b1;
  endtask

  // Called right after reset release with locked already high.
  task automatic seq_to_run(input string tag);
    steps(RST_HOLD - 1, tag, vec(0, 0, 0, 3'd0, exp_llc));
    steps(11, tag, vec(1, 0, 0, 3'd0, exp_llc));
    step(tag, vec(1, 1, 0, 3'd0, exp_llc));
  endtask

  // From RUN: locked low for len cycles, then back through PLL_RST/WAIT_LOCK/STABLE to RUN.
  task automatic dip(input int unsigned len, input logic clr, input logic full, input string tag);
    logic [14:0] e;
    locked = 1'b0;
    for (int unsigned k = 1; k <= LAT + 15; k++) begin
      clear_stats = clr && (k == LAT);
      if (k == LAT) exp_llc = clr ? 8'd0 : ((exp_llc == 8'hFF) ? 8'hFF : exp_llc + 8'd1);
      if (k < LAT)            e = vec(1, 1, 0, 3'd0, exp_llc);
      else if (k <= LAT + 3)  e = vec(0, 0, 0, 3'd0, exp_llc);
      else if (k < LAT + 15)  e = vec(1, 0, 0, 3'd0, exp_llc);
      else                    e = vec(1, 1, 0, 3'd0, exp_llc);
      if (full || k == LAT || k == LAT + 15) step(tag, e);
      else tick();
      if (k == len) locked = 1'b1;
    end
    clear_stats = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: lock at cycle 8, ready 10 cycles after STABLE entry
    do_reset(1'b0);
    steps(RST_HOLD - 1, "t1 resetb low", vec(0, 0, 0, 3'd0, 8'd0));
    steps(5, "t1 resetb high", vec(1, 0, 0, 3'd0, 8'd0));
    locked = 1'b1;
    steps(12, "t1 wait/stable", vec(1, 0, 0, 3'd0, 8'd0));
    step("t1 run", vec(1, 1, 0, 3'd0, 8'd0));

    // Test 3: lock loss in RUN
`ifdef PLL_SEQ_LOCK_FILTER_EN
    locked = 1'b0;
    tick();
    locked = 1'b1;
    steps(12, "t3 glitch ignored", vec(1, 1, 0, 3'd0, exp_llc));
`else
    dip(1, 1'b0, 1'b1, "t3 1-cycle loss");
`endif
    dip(4, 1'b0, 1'b1, "t3 4-cycle loss");

    // Test 5: saturation, then clear beating a simultaneous loss
    while (exp_llc != 8'hFF) dip(4, 1'b0, 1'b0, "t5 ramp");
    dip(4, 1'b0, 1'b1, "t5 saturated");
    dip(4, 1'b1, 1'b1, "t5 clear with loss");

    // Test 2: no lock -> retries then terminal fail
    do_reset(1'b0);
    steps(RST_HOLD - 1, "t2 pulse0", vec(0, 0, 0, 3'd0, 8'd0));
    steps(TIMEOUT, "t2 wait0", vec(1, 0, 0, 3'd0, 8'd0));
    for (int unsigned r = 1; r <= MAXR; r++) begin
      steps(RST_HOLD, "t2 pulse", vec(0, 0, 0, 3'(r), 8'd0));
      steps(TIMEOUT, "t2 wait", vec(1, 0, 0, 3'(r), 8'd0));
    end
    steps(5, "t2 fail", vec(0, 0, 1, 3'(MAXR), 8'd0));
    locked = 1'b1;
    steps(20, "t2 fail sticky", vec(0, 0, 1, 3'(MAXR), 8'd0));

    // Test 4: dip in STABLE at count 5, with retry_count=1 carried through
    do_reset(1'b0);
    steps(RST_HOLD - 1, "t4 pulse0", vec(0, 0, 0, 3'd0, 8'd0));
    steps(TIMEOUT, "t4 wait0", vec(1, 0, 0, 3'd0, 8'd0));
    step("t4 retry", vec(0, 0, 0, 3'd1, 8'd0));
    locked = 1'b1;
    steps(RST_HOLD - 1, "t4 pulse1", vec(0, 0, 0, 3'd1, 8'd0));
    steps(5, "t4 wait/stable", vec(1, 0, 0, 3'd1, 8'd0));
    locked = 1'b0;
    step("t4 dip", vec(1, 0, 0, 3'd1, 8'd0));
    locked = 1'b1;
`ifdef PLL_SEQ_LOCK_FILTER_EN
    steps(5, "t4 stable", vec(1, 0, 0, 3'd1, 8'd0));
`else
    steps(12, "t4 restable", vec(1, 0, 0, 3'd1, 8'd0));
`endif
    step("t4 run", vec(1, 1, 0, 3'd1, 8'd0));

    // Test 6: reset asserted in WAIT_LOCK
    do_reset(1'b0);
    steps(RST_HOLD - 1, "t6 pulse", vec(0, 0, 0, 3'd0, 8'd0));
    steps(7, "t6 wait", vec(1, 0, 0, 3'd0, 8'd0));
    rst_n = 1'b0;
    locked = 1'b1;
    steps(2, "t6 abort", vec(0, 0, 0, 3'd0, 8'd0));
    rst_n = 1'b1;
    exp_llc = 8'd0;
    seq_to_run("t6 restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
